// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared types and constants for the system bus arbiter
package sysbus_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD, ARB_WAIT_WR} arb_state_t;
  typedef enum logic {OWNER_I, OWNER_D} owner_t;
  localparam int DEF_TAG_WIDTH = 13;
  localparam int WRITE_TAG_BIT = DEF_TAG_WIDTH - 1;
endpackage

// File: rtl/sysbus_arbiter_rr_grant2.sv
// rr_grant2: two-way round-robin picker; a tie goes to the side not granted last
module rr_grant2
  import sysbus_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_last,
  output logic o_grant,
  output logic o_valid
);
  assign o_valid = i_req_i | i_req_d;
  assign o_grant = (i_req_i && i_req_d) ? (i_last == OWNER_I) : i_req_d;
endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin sharing of the system bus between icache (I) and data side (D)
module sysbus_arbiter
  import sysbus_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int TAG_WIDTH  = 13,
  parameter int LINE_BEATS = 8,
  parameter int TIMEOUT    = 1023
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_reqcyc,
  input  logic [WIDTH-1:0]     i_req,
  input  logic [TAG_WIDTH-1:0] i_reqtag,
  output logic                 i_reqack,
  output logic                 i_respcyc,
  output logic [WIDTH-1:0]     i_resp,
  output logic [TAG_WIDTH-1:0] i_resptag,
  input  logic                 d_reqcyc,
  input  logic [WIDTH-1:0]     d_req,
  input  logic [TAG_WIDTH-1:0] d_reqtag,
  input  logic [WIDTH-1:0]     d_reqdata,
  output logic                 d_reqack,
  output logic                 d_respcyc,
  output logic [WIDTH-1:0]     d_resp,
  output logic [TAG_WIDTH-1:0] d_resptag,
  output logic                 d_writeack,
  output logic                 bus_reqcyc,
  output logic [WIDTH-1:0]     bus_req,
  output logic [TAG_WIDTH-1:0] bus_reqtag,
  output logic [WIDTH-1:0]     bus_reqdata,
  input  logic                 bus_reqack,
  input  logic                 bus_respcyc,
  input  logic [WIDTH-1:0]     bus_resp,
  input  logic [TAG_WIDTH-1:0] bus_resptag,
  output logic                 bus_respack,
  input  logic                 bus_writeack,
  output logic                 timeout_err
);
  localparam int WB = TAG_WIDTH - 1;
  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_t           r_state;
  owner_t               r_owner;
  owner_t               r_last;
  logic [BW-1:0]        r_beats;
  logic [WW-1:0]        r_wdog;
  logic                 w_gnt;
  logic                 w_gvalid;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_wack;
  logic                 w_waiting;
  logic                 w_expire;
  logic [TAG_WIDTH-1:0] w_itag;

  rr_grant2 u_rr (
    .i_req_i (i_reqcyc),
    .i_req_d (d_reqcyc),
    .i_last  (r_last),
    .o_grant (w_gnt),
    .o_valid (w_gvalid)
  );

  // icache only ever reads, so its write marker is cleared before reaching the bus
  assign w_itag      = i_reqtag & ~(TAG_WIDTH'(1) << WB);
  // a beat counts in WAIT_RD, or in ISSUE when it arrives together with the accept of a read
  assign w_beat      = bus_respcyc && ((r_state == ARB_WAIT_RD) ||
                       (r_state == ARB_ISSUE && bus_reqack && !bus_reqtag[WB]));
  assign w_last_beat = w_beat && (r_beats == BW'(LINE_BEATS - 1));
  assign w_wack      = bus_writeack && (r_state == ARB_WAIT_WR);
  assign w_waiting   = (r_state == ARB_WAIT_RD) || (r_state == ARB_WAIT_WR);
  assign w_expire    = w_waiting && !w_beat && !w_wack && (r_wdog == WW'(TIMEOUT - 1));

  // grant, request latching and transaction state sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWNER_I;
      r_last      <= OWNER_D;
      i_reqack    <= 1'b0;
      d_reqack    <= 1'b0;
      bus_reqcyc  <= 1'b0;
      bus_req     <= '0;
      bus_reqtag  <= '0;
      bus_reqdata <= '0;
    end else begin
      i_reqack <= 1'b0;
      d_reqack <= 1'b0;
      if (r_state == ARB_IDLE && w_gvalid) begin
        r_owner     <= owner_t'(w_gnt);
        r_last      <= owner_t'(w_gnt);
        i_reqack    <= !w_gnt;
        d_reqack    <= w_gnt;
        bus_reqcyc  <= 1'b1;
        bus_req     <= w_gnt ? d_req : i_req;
        bus_reqtag  <= w_gnt ? d_reqtag : w_itag;
        bus_reqdata <= w_gnt ? d_reqdata : '0;
        r_state     <= ARB_ISSUE;
      end else if (r_state == ARB_ISSUE && bus_reqack) begin
        bus_reqcyc <= 1'b0;
        r_state    <= bus_reqtag[WB] ? ARB_WAIT_WR : (w_last_beat ? ARB_IDLE : ARB_WAIT_RD);
      end else if (w_last_beat || w_wack || w_expire) begin
        r_state <= ARB_IDLE;
      end
    end
  end

  // beat counter and idle-bus watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beats <= '0;
      r_wdog  <= '0;
    end else begin
      r_beats <= (w_expire || w_last_beat) ? '0 : (w_beat ? r_beats + 1'b1 : r_beats);
      r_wdog  <= (!w_waiting || w_beat || w_wack || w_expire) ? '0 : r_wdog + 1'b1;
    end
  end

  // steer response beats and write completion to the owning requester
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_respack <= 1'b0;
      i_respcyc   <= 1'b0;
      i_resp      <= '0;
      i_resptag   <= '0;
      d_respcyc   <= 1'b0;
      d_resp      <= '0;
      d_resptag   <= '0;
      d_writeack  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      bus_respack <= w_beat;
      i_respcyc   <= w_beat && (r_owner == OWNER_I);
      d_respcyc   <= w_beat && (r_owner == OWNER_D);
      d_writeack  <= w_wack;
      timeout_err <= timeout_err | w_expire;
      if (w_beat && r_owner == OWNER_I) begin
        i_resp    <= bus_resp;
        i_resptag <= bus_resptag;
      end
      if (w_beat && r_owner == OWNER_D) begin
        d_resp    <= bus_resp;
        d_resptag <= bus_resptag;
      end
    end
  end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed table-driven and sequence checks of sysbus_arbiter
module tb_sysbus_arbiter;
  localparam int TIMEOUT = 1023;
  localparam int LB = 8;

  logic        clk = 0, reset = 1;
  logic        i_reqcyc = 0, d_reqcyc = 0;
  logic [63:0] i_req = '0, d_req = '0, d_reqdata = '0;
  logic [12:0] i_reqtag = '0, d_reqtag = '0;
  logic        i_reqack, i_respcyc, d_reqack, d_respcyc, d_writeack;
  logic [63:0] i_resp, d_resp;
  logic [12:0] i_resptag, d_resptag;
  logic        bus_reqcyc, bus_respack, timeout_err;
  logic [63:0] bus_req, bus_reqdata;
  logic [12:0] bus_reqtag;
  logic        bus_reqack = 0, bus_respcyc = 0, bus_writeack = 0;
  logic [63:0] bus_resp = '0;
  logic [12:0] bus_resptag = '0;
  int total = 0, bad = 0;

  sysbus_arbiter dut (
    .clk(clk), .reset(reset),
    .i_reqcyc(i_reqcyc), .i_req(i_req), .i_reqtag(i_reqtag), .i_reqack(i_reqack),
    .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag),
    .d_reqcyc(d_reqcyc), .d_req(d_req), .d_reqtag(d_reqtag), .d_reqdata(d_reqdata),
    .d_reqack(d_reqack), .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag),
    .d_writeack(d_writeack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqdata(bus_reqdata),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack), .bus_writeack(bus_writeack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] data;
    logic [12:0] exp_tag;
    logic [63:0] base;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic is_d, input logic [63:0] addr, input logic [12:0] tag,
                       input logic [63:0] data, input logic [12:0] exp_tag);
    if (is_d) begin
      d_reqcyc = 1; d_req = addr; d_reqtag = tag; d_reqdata = data;
    end else begin
      i_reqcyc = 1; i_req = addr; i_reqtag = tag;
    end
    @(negedge clk);
    chk("reqack_owner", is_d ? d_reqack : i_reqack, 1);
    chk("reqack_other", is_d ? i_reqack : d_reqack, 0);
    chk("bus_reqcyc", bus_reqcyc, 1);
    chk("bus_req", bus_req, addr);
    chk("bus_reqtag", 64'(bus_reqtag), 64'(exp_tag));
    if (is_d) chk("bus_reqdata", bus_reqdata, data);
    if (is_d) d_reqcyc = 0; else i_reqcyc = 0;
  endtask

  task automatic accept(input logic is_d);
    bus_reqack = 1;
    @(negedge clk);
    bus_reqack = 0;
    chk("reqcyc_drop", bus_reqcyc, 0);
    chk("reqack_pulse", is_d ? d_reqack : i_reqack, 0);
  endtask

  task automatic beats(input logic is_d, input logic [63:0] base, input logic [12:0] tag, input int first);
    for (int k = first; k < LB; k++) begin
      bus_respcyc = 1; bus_resp = base + 64'(k); bus_resptag = tag;
      @(negedge clk);
      chk("own_respcyc", is_d ? d_respcyc : i_respcyc, 1);
      chk("own_resp", is_d ? d_resp : i_resp, base + 64'(k));
      chk("own_resptag", 64'(is_d ? d_resptag : i_resptag), 64'(tag));
      chk("other_respcyc", is_d ? i_respcyc : d_respcyc, 0);
      chk("other_reqack", is_d ? i_reqack : d_reqack, 0);
      chk("respack", bus_respack, 1);
    end
    bus_respcyc = 0;
    @(negedge clk);
    chk("own_respcyc_end", is_d ? d_respcyc : i_respcyc, 0);
    chk("respack_end", bus_respack, 0);
  endtask

  task automatic wr_done();
    bus_writeack = 1;
    @(negedge clk);
    bus_writeack = 0;
    chk("d_writeack", d_writeack, 1);
    chk("wr_no_dresp", d_respcyc, 0);
    chk("wr_no_iresp", i_respcyc, 0);
    chk("wr_no_respack", bus_respack, 0);
    @(negedge clk);
    chk("d_writeack_pulse", d_writeack, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, 64'({i_reqack, d_reqack, i_respcyc, d_respcyc, d_writeack,
                           bus_reqcyc, bus_respack, timeout_err}), 0);
    chk({nm, "_bus_req"}, bus_req, 0);
    chk({nm, "_bus_tag"}, 64'(bus_reqtag), 0);
    chk({nm, "_i_resp"}, i_resp, 0);
  endtask

  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n, stray;
    logic [63:0] a;
    tbl[0] = '{1'b0, 64'h1000, 13'h0005, 64'h0, 13'h0005, 64'h0};
    tbl[1] = '{1'b1, 64'h2000, 13'h1003, 64'hDEAD, 13'h1003, 64'h0};
    tbl[2] = '{1'b1, 64'h3000, 13'h0042, 64'h1234, 13'h0042, 64'h100};
    tbl[3] = '{1'b0, 64'h3800, 13'h1FFF, 64'h0, 13'h0FFF, 64'h200};
    tbl[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 13'h1000, '1, 13'h1000, 64'h0};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 0;
    @(negedge clk);
    chk_zero("post_reset");

    // simultaneous requests: I wins first, D granted on the first IDLE after I's last beat
    i_reqcyc = 1; i_req = 64'h1100; i_reqtag = 13'h0001;
    d_reqcyc = 1; d_req = 64'h4000; d_reqtag = 13'h0007; d_reqdata = 64'h77;
    @(negedge clk);
    chk("tie_i_ack", i_reqack, 1);
    chk("tie_d_ack", d_reqack, 0);
    chk("tie_bus_req", bus_req, 64'h1100);
    i_reqcyc = 0;
    accept(0);
    beats(0, 64'h10, 13'h0001, 0);
    chk("rr_d_ack", d_reqack, 1);
    chk("rr_bus_req", bus_req, 64'h4000);
    d_reqcyc = 0;
    accept(1);
    beats(1, 64'h20, 13'h0007, 0);

    // reqack withheld five cycles with a stray beat in ISSUE, then accept together with beat 0
    issue(1, 64'h8000, 13'h0020, 64'h55, 13'h0020);
    for (int c = 0; c < 5; c++) begin
      bus_respcyc = (c == 2); bus_resp = 64'hBAD;
      @(negedge clk);
      chk("hold_reqcyc", bus_reqcyc, 1);
      chk("hold_req", bus_req, 64'h8000);
      chk("hold_data", bus_reqdata, 64'h55);
      chk("stray_respack", bus_respack, 0);
      chk("stray_respcyc", d_respcyc, 0);
    end
    bus_reqack = 1; bus_respcyc = 1; bus_resp = 64'h300; bus_resptag = 13'h0020;
    @(negedge clk);
    bus_reqack = 0;
    chk("ack_beat_reqcyc", bus_reqcyc, 0);
    chk("ack_beat_respcyc", d_respcyc, 1);
    chk("ack_beat_resp", d_resp, 64'h300);
    beats(1, 64'h300, 13'h0020, 1);

    // watchdog abort on a read that never gets a response
    issue(0, 64'h5000, 13'h0009, 64'h0, 13'h0009);
    accept(0);
    chk("err_before", timeout_err, 0);
    n = 0; stray = 0;
    while (n < TIMEOUT + 5 && !timeout_err) begin
      @(negedge clk);
      n++;
      if (i_respcyc || d_respcyc) stray++;
    end
    chk("timeout_cycles", 64'(n), 64'(TIMEOUT));
    chk("timeout_err", timeout_err, 1);
    chk("timeout_no_resp", 64'(stray), 0);
    issue(1, 64'h6000, 13'h0011, 64'h66, 13'h0011);
    accept(1);
    beats(1, 64'h400, 13'h0011, 0);
    chk("err_sticky", timeout_err, 1);

    // asynchronous reset in the middle of a read after beat 3
    issue(0, 64'h7000, 13'h000A, 64'h0, 13'h000A);
    accept(0);
    for (int k = 0; k < 4; k++) begin
      bus_respcyc = 1; bus_resp = 64'(k); bus_resptag = 13'h000A;
      @(negedge clk);
    end
    bus_respcyc = 0;
    chk("mid_respcyc", i_respcyc, 1);
    #2 reset = 1;
    #1 chk_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    // unexpected response and writeack while IDLE are ignored
    bus_respcyc = 1; bus_writeack = 1;
    @(negedge clk);
    bus_respcyc = 0; bus_writeack = 0;
    chk("idle_respack", bus_respack, 0);
    chk("idle_writeack", d_writeack, 0);
    chk("idle_respcyc", i_respcyc, 0);

    // single-requester transactions, reads and writes
    for (int v = 0; v < 5; v++) begin
      a = tbl[v].addr;
      issue(tbl[v].is_d, a, tbl[v].tag, tbl[v].data, tbl[v].exp_tag);
      accept(tbl[v].is_d);
      if (tbl[v].exp_tag[12]) wr_done();
      else beats(tbl[v].is_d, tbl[v].base, tbl[v].exp_tag, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
